// File: rtl/stage_wb_if.sv
// MEM/ID-to-WB connection bundle for the write-back stage.
// The master side is the rest of the pipeline; the slave side is stage_wb.
interface stage_wb_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   stall;
  logic                   valid_in;
  logic [2:0]             dest_in;
  logic                   load_regfile_in;
  logic                   load_cc_in;
  logic [1:0]             wb_sel_in;
  logic [15:0]            alu_in;
  logic [15:0]            mem_in;
  logic [15:0]            pc_in;
  logic                   addr_lsb_in;
  logic [2:0]             id_sr1;
  logic [2:0]             id_sr2;
  logic [2:0]             regfile_dest;
  logic [15:0]            regfile_data;
  logic                   regfile_load;
  logic [15:0]            stage_WB_regfile_data;
  logic                   forward_ID_A_mux_sel;
  logic                   forward_ID_B_mux_sel;
  logic [2:0]             cc_out;
  logic [COUNT_WIDTH-1:0] retired_count;

  modport master (
    output stall, valid_in, dest_in, load_regfile_in, load_cc_in, wb_sel_in,
           alu_in, mem_in, pc_in, addr_lsb_in, id_sr1, id_sr2,
    input  regfile_dest, regfile_data, regfile_load, stage_WB_regfile_data,
           forward_ID_A_mux_sel, forward_ID_B_mux_sel, cc_out, retired_count
  );

  modport slave (
    input  stall, valid_in, dest_in, load_regfile_in, load_cc_in, wb_sel_in,
           alu_in, mem_in, pc_in, addr_lsb_in, id_sr1, id_sr2,
    output regfile_dest, regfile_data, regfile_load, stage_WB_regfile_data,
           forward_ID_A_mux_sel, forward_ID_B_mux_sel, cc_out, retired_count
  );
endinterface

// File: rtl/stage_wb.sv
// LC-3b write-back stage: MEM/WB register, result formatting, register-file
// write port, condition codes, ID forwarding selects and retired counter.
module stage_wb #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  stage_wb_if.slave bus
);

  logic                   valid_q;
  logic [2:0]             dest_q;
  logic                   load_rf_q;
  logic                   load_cc_q;
  logic [1:0]             wb_sel_q;
  logic [15:0]            alu_q;
  logic [15:0]            mem_q;
  logic [15:0]            pc_q;
  logic                   addr_lsb_q;
  logic [2:0]             cc_q;
  logic [2:0]             cc_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  logic [7:0]  byte_sel;
  logic [15:0] result;
  logic        rf_load;
  logic        retire;

  always_comb begin
    byte_sel = addr_lsb_q ? mem_q[15:8] : mem_q[7:0];
    result   = alu_q;
    unique case (wb_sel_q)
      2'd0: result = alu_q;
      2'd1: result = mem_q;
      2'd2: result = {{8{byte_sel[7]}}, byte_sel};
      2'd3: result = pc_q;
    endcase
  end

  assign rf_load = valid_q & load_rf_q;
  // CC and counter act on the instruction leaving WB, not the one entering.
  assign retire  = valid_q & ~bus.stall;

  always_comb begin
    cc_d    = cc_q;
    count_d = count_q;
    if (retire && load_cc_q) begin
      cc_d[2] = result[15];
      cc_d[1] = (result == 16'h0000);
      cc_d[0] = ~result[15] & (result != 16'h0000);
    end
    if (retire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      dest_q     <= 3'd0;
      load_rf_q  <= 1'b0;
      load_cc_q  <= 1'b0;
      wb_sel_q   <= 2'd0;
      alu_q      <= 16'h0000;
      mem_q      <= 16'h0000;
      pc_q       <= 16'h0000;
      addr_lsb_q <= 1'b0;
      cc_q       <= 3'b010;
      count_q    <= '0;
    end else if (!bus.stall) begin
      valid_q    <= bus.valid_in;
      dest_q     <= bus.dest_in;
      load_rf_q  <= bus.load_regfile_in;
      load_cc_q  <= bus.load_cc_in;
      wb_sel_q   <= bus.wb_sel_in;
      alu_q      <= bus.alu_in;
      mem_q      <= bus.mem_in;
      pc_q       <= bus.pc_in;
      addr_lsb_q <= bus.addr_lsb_in;
      cc_q       <= cc_d;
      count_q    <= count_d;
    end
  end

  assign bus.regfile_dest          = dest_q;
  assign bus.regfile_data          = result;
  assign bus.regfile_load          = rf_load;
  assign bus.stage_WB_regfile_data = result;
  assign bus.forward_ID_A_mux_sel  = rf_load & (dest_q == bus.id_sr1);
  assign bus.forward_ID_B_mux_sel  = rf_load & (dest_q == bus.id_sr2);
  assign bus.cc_out                = cc_q;
  assign bus.retired_count         = count_q;

endmodule

// File: tb/tb_stage_wb.sv
// Directed self-checking bench for stage_wb, built with a 4-bit retired
// counter so that the wrap-around can be reached quickly.
module tb_stage_wb;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  stage_wb_if #(.COUNT_WIDTH(4)) bus ();

  stage_wb #(.COUNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.valid_in        = 1'b0;
    bus.dest_in         = 3'd0;
    bus.load_regfile_in = 1'b0;
    bus.load_cc_in      = 1'b0;
    bus.wb_sel_in       = 2'd0;
    bus.alu_in          = 16'h0000;
    bus.mem_in          = 16'h0000;
    bus.pc_in           = 16'h0000;
    bus.addr_lsb_in     = 1'b0;
    bus.id_sr1          = 3'd0;
    bus.id_sr2          = 3'd0;
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic lrf, input logic lcc,
                       input logic [1:0] sel, input logic [15:0] alu, input logic [15:0] mem,
                       input logic [15:0] pc, input logic lsb);
    bus.valid_in        = v;
    bus.dest_in         = d;
    bus.load_regfile_in = lrf;
    bus.load_cc_in      = lcc;
    bus.wb_sel_in       = sel;
    bus.alu_in          = alu;
    bus.mem_in          = mem;
    bus.pc_in           = pc;
    bus.addr_lsb_in     = lsb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.valid_in = 1'b1;
    bus.load_regfile_in = 1'b1;
    bus.alu_in = 16'hBEEF;
    step();
    checks++;
    if (bus.regfile_load !== 1'b0) begin
      errors++; $display("FAIL reset_load: got %b want 0", bus.regfile_load);
    end
    checks++;
    if (bus.regfile_data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h want 0000", bus.regfile_data);
    end
    checks++;
    if (bus.cc_out !== 3'b010) begin
      errors++; $display("FAIL reset_cc: got %b want 010", bus.cc_out);
    end
    checks++;
    if (bus.retired_count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", bus.retired_count);
    end
    checks++;
    if (bus.forward_ID_A_mux_sel !== 1'b0 || bus.forward_ID_B_mux_sel !== 1'b0) begin
      errors++; $display("FAIL reset_fwd: got %b%b want 00",
                         bus.forward_ID_A_mux_sel, bus.forward_ID_B_mux_sel);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_alu_writeback();
    do_reset();
    drive(1'b1, 3'd3, 1'b1, 1'b1, 2'd0, 16'h8001, 16'h0000, 16'h0000, 1'b0);
    step();
    checks++;
    if (bus.regfile_load !== 1'b1 || bus.regfile_dest !== 3'd3) begin
      errors++; $display("FAIL alu_load_dest: got %b/%0d want 1/3",
                         bus.regfile_load, bus.regfile_dest);
    end
    checks++;
    if (bus.regfile_data !== 16'h8001 || bus.stage_WB_regfile_data !== 16'h8001) begin
      errors++; $display("FAIL alu_data: got %h/%h want 8001",
                         bus.regfile_data, bus.stage_WB_regfile_data);
    end
    checks++;
    if (bus.cc_out !== 3'b010 || bus.retired_count !== 4'd0) begin
      errors++; $display("FAIL alu_cc_early: got %b/%0d want 010/0",
                         bus.cc_out, bus.retired_count);
    end
    clear_inputs();
    step();
    checks++;
    if (bus.cc_out !== 3'b100) begin
      errors++; $display("FAIL alu_cc: got %b want 100", bus.cc_out);
    end
    checks++;
    if (bus.retired_count !== 4'd1) begin
      errors++; $display("FAIL alu_count: got %0d want 1", bus.retired_count);
    end
    checks++;
    if (bus.regfile_load !== 1'b0) begin
      errors++; $display("FAIL alu_bubble_load: got %b want 0", bus.regfile_load);
    end
  endtask

  task automatic test_byte_load();
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 1'b1, 2'd2, 16'h0000, 16'h7F80, 16'h0000, 1'b0);
    step();
    checks++;
    if (bus.regfile_data !== 16'hFF80) begin
      errors++; $display("FAIL byte_lo_data: got %h want ff80", bus.regfile_data);
    end
    drive(1'b1, 3'd1, 1'b1, 1'b1, 2'd2, 16'h0000, 16'h7F80, 16'h0000, 1'b1);
    step();
    checks++;
    if (bus.regfile_data !== 16'h007F) begin
      errors++; $display("FAIL byte_hi_data: got %h want 007f", bus.regfile_data);
    end
    checks++;
    if (bus.cc_out !== 3'b100) begin
      errors++; $display("FAIL byte_lo_cc: got %b want 100", bus.cc_out);
    end
    clear_inputs();
    step();
    checks++;
    if (bus.cc_out !== 3'b001 || bus.retired_count !== 4'd2) begin
      errors++; $display("FAIL byte_hi_cc: got %b/%0d want 001/2",
                         bus.cc_out, bus.retired_count);
    end
  endtask

  task automatic test_word_pc();
    do_reset();
    // Seed a positive CC first so the zero result visibly changes it.
    drive(1'b1, 3'd2, 1'b1, 1'b1, 2'd0, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    step();
    drive(1'b1, 3'd2, 1'b1, 1'b1, 2'd1, 16'h1111, 16'h0000, 16'h2222, 1'b1);
    step();
    checks++;
    if (bus.regfile_data !== 16'h0000 || bus.cc_out !== 3'b001) begin
      errors++; $display("FAIL word_zero: got %h/%b want 0000/001",
                         bus.regfile_data, bus.cc_out);
    end
    drive(1'b1, 3'd7, 1'b1, 1'b0, 2'd3, 16'h1111, 16'hFFFF, 16'h1234, 1'b0);
    step();
    checks++;
    if (bus.regfile_data !== 16'h1234 || bus.cc_out !== 3'b010) begin
      errors++; $display("FAIL pc_data: got %h/%b want 1234/010",
                         bus.regfile_data, bus.cc_out);
    end
    clear_inputs();
    step();
    // PC link with load_cc = 0 must leave the zero CC alone.
    checks++;
    if (bus.cc_out !== 3'b010 || bus.retired_count !== 4'd3) begin
      errors++; $display("FAIL pc_no_cc: got %b/%0d want 010/3",
                         bus.cc_out, bus.retired_count);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.id_sr1 = 3'd5;
    bus.id_sr2 = 3'd2;
    drive(1'b1, 3'd5, 1'b1, 1'b0, 2'd0, 16'h00AA, 16'h0000, 16'h0000, 1'b0);
    step();
    checks++;
    if (bus.forward_ID_A_mux_sel !== 1'b1 || bus.forward_ID_B_mux_sel !== 1'b0) begin
      errors++; $display("FAIL fwd_a: got %b%b want 10",
                         bus.forward_ID_A_mux_sel, bus.forward_ID_B_mux_sel);
    end
    bus.id_sr2 = 3'd5;
    #1;
    checks++;
    if (bus.forward_ID_B_mux_sel !== 1'b1) begin
      errors++; $display("FAIL fwd_b_comb: got %b want 1", bus.forward_ID_B_mux_sel);
    end
    bus.id_sr2 = 3'd2;
    drive(1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 16'h00AA, 16'h0000, 16'h0000, 1'b0);
    step();
    checks++;
    if (bus.forward_ID_A_mux_sel !== 1'b0 || bus.forward_ID_B_mux_sel !== 1'b0) begin
      errors++; $display("FAIL fwd_noload: got %b%b want 00",
                         bus.forward_ID_A_mux_sel, bus.forward_ID_B_mux_sel);
    end
    drive(1'b0, 3'd5, 1'b1, 1'b1, 2'd0, 16'h8000, 16'h0000, 16'h0000, 1'b0);
    bus.id_sr2 = 3'd5;
    step();
    checks++;
    if (bus.forward_ID_A_mux_sel !== 1'b0 || bus.forward_ID_B_mux_sel !== 1'b0 ||
        bus.regfile_load !== 1'b0) begin
      errors++; $display("FAIL fwd_bubble: got %b%b load %b want 00 load 0",
                         bus.forward_ID_A_mux_sel, bus.forward_ID_B_mux_sel,
                         bus.regfile_load);
    end
    clear_inputs();
    step();
    // The bubble with load_cc set must not touch CC or the counter.
    checks++;
    if (bus.cc_out !== 3'b010 || bus.retired_count !== 4'd2) begin
      errors++; $display("FAIL bubble_state: got %b/%0d want 010/2",
                         bus.cc_out, bus.retired_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 3'd6, 1'b1, 1'b1, 2'd0, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'(i), 1'b0, 1'b1, 2'd1, 16'(16'h8000 + i), 16'h8000, 16'h0000, 1'b0);
      step();
      checks++;
      if (bus.regfile_data !== 16'h0005 || bus.regfile_dest !== 3'd6 ||
          bus.regfile_load !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h/%0d/%b want 0005/6/1", i,
                           bus.regfile_data, bus.regfile_dest, bus.regfile_load);
      end
      checks++;
      if (bus.cc_out !== 3'b010 || bus.retired_count !== 4'd0) begin
        errors++; $display("FAIL stall_state[%0d]: got %b/%0d want 010/0", i,
                           bus.cc_out, bus.retired_count);
      end
    end
    clear_inputs();
    step();
    checks++;
    if (bus.cc_out !== 3'b001 || bus.retired_count !== 4'd1) begin
      errors++; $display("FAIL stall_release: got %b/%0d want 001/1",
                         bus.cc_out, bus.retired_count);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    // 17 edges: the first only captures, the other 16 retire and wrap to 0.
    for (int i = 0; i < 17; i++) begin
      step();
    end
    checks++;
    if (bus.retired_count !== 4'd0) begin
      errors++; $display("FAIL wrap_zero: got %0d want 0", bus.retired_count);
    end
    clear_inputs();
    step();
    checks++;
    if (bus.retired_count !== 4'd1) begin
      errors++; $display("FAIL wrap_17: got %0d want 1", bus.retired_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 3'd1, 1'b1, 1'b1, 2'd0, 16'h8000, 16'h0000, 16'h0000, 1'b0);
    step();
    step();
    checks++;
    if (bus.cc_out !== 3'b100 || bus.retired_count !== 4'd1 ||
        bus.regfile_load !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got %b/%0d/%b want 100/1/1",
                         bus.cc_out, bus.retired_count, bus.regfile_load);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.regfile_load !== 1'b0 || bus.cc_out !== 3'b010 ||
        bus.retired_count !== 4'd0 || bus.regfile_data !== 16'h0000) begin
      errors++; $display("FAIL areset: got load %b cc %b cnt %0d data %h want 0/010/0/0000",
                         bus.regfile_load, bus.cc_out, bus.retired_count, bus.regfile_data);
    end
    step();
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_writeback();
    test_byte_load();
    test_word_pc();
    test_forwarding();
    test_stall();
    test_counter_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
